// File: rtl/csr_spi_master_if.sv
// csr_spi_master_if
//   Host-side bus of the CSR/PROM SPI master. It carries the request
//   strobe, the write-byte stream, the read-byte stream and the done pulse.
//   The master modport is the host that issues requests. The slave modport
//   is the SPI master block that serves them.
//   Signals:
//     req_valid/req_ready    request handshake
//     req_we, req_target     direction and target (00 CSR, 01 NKMD PROM)
//     req_addr, req_len      address and data byte count
//     wdata/wvalid/wready    write byte stream into the block
//     rdata/rvalid/rready    captured read bytes out of the block
//     done                   one-cycle pulse when ss returns high
interface csr_spi_master_if #(
    parameter int LEN_W = 12
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_target;
    logic [19:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic [7:0]       wdata;
    logic             wvalid;
    logic             wready;
    logic [7:0]       rdata;
    logic             rvalid;
    logic             rready;
    logic             done;

    modport master (
        output req_valid, req_we, req_target, req_addr, req_len,
        output wdata, wvalid, rready,
        input  req_ready, wready, rdata, rvalid, done
    );

    modport slave (
        input  req_valid, req_we, req_target, req_addr, req_len,
        input  wdata, wvalid, rready,
        output req_ready, wready, rdata, rvalid, done
    );
endinterface

// File: rtl/csr_spi_master.sv
// csr_spi_master
//   SPI master for the dmix CSR / NKMD-PROM SPI command protocol (mode 0).
//   It accepts one request at a time and shifts out the header bytes. It then
//   streams write bytes from the host, or zero bytes for reads. Read bytes
//   that miso returns after the status bytes are handed back to the host.
//   Ports:
//     clk, rst    clock and synchronous active-high reset
//     bus         csr_spi_master_if.slave (request / write / read / done)
//     sck, mosi   SPI clock (idle low) and data out, MSB first
//     miso        SPI data in, sampled on sck rise
//     ss          slave select, active low
module csr_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 12,
    parameter int SS_GAP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    csr_spi_master_if.slave  bus,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic             ss
);
    localparam int BC_W  = LEN_W + 2;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SS_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, HOLD, GAP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [BC_W-1:0]   total_q, total_d;
    logic              we_q, we_d;
    logic [1:0]        target_q, target_d;
    logic [19:0]       addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic [6:0]        rx_q, rx_d;
    logic              sck_q, sck_d;
    logic              ss_q, ss_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              done_q, done_d;

    logic              wready_c;
    logic              load_go;
    logic [7:0]        load_byte;
    logic [7:0]        hdr_byte;
    logic [BC_W-1:0]   hdr_len;
    logic [BC_W-1:0]   data_bytes;
    logic              rd_capture;

    // PROM requests carry a third address byte in the header.
    assign hdr_len = (target_q == 2'b01) ? BC_W'(3) : BC_W'(2);

    // Only CSR reads return data. The header byte slot and the one after it
    // return slave status, so capture starts at byte index 3 and runs
    // through the trailing dummy byte.
    assign rd_capture = !we_q && (target_q == 2'b00) &&
                        (byte_cnt_q >= BC_W'(3)) && (byte_cnt_q < total_q);

    always_comb begin
        case (byte_cnt_q[1:0])
            2'd0:    hdr_byte = {we_q, 1'b0, target_q, addr_q[19:16]};
            2'd1:    hdr_byte = addr_q[15:8];
            default: hdr_byte = addr_q[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            total_q    <= '0;
            we_q       <= 1'b0;
            target_q   <= '0;
            addr_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            sck_q      <= 1'b0;
            ss_q       <= 1'b1;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            total_q    <= total_d;
            we_q       <= we_d;
            target_q   <= target_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sck_q      <= sck_d;
            ss_q       <= ss_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        total_d    = total_q;
        we_d       = we_q;
        target_d   = target_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        sck_d      = sck_q;
        ss_d       = ss_q;
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q & ~bus.rready;
        done_d     = 1'b0;
        wready_c   = 1'b0;
        load_go    = 1'b0;
        load_byte  = hdr_byte;
        data_bytes = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d       = bus.req_we;
                    target_d   = bus.req_target;
                    addr_d     = bus.req_addr;
                    byte_cnt_d = '0;
                    cnt_d      = '0;
                    ss_d       = 1'b0;
                    state_d    = SETUP;
                    // Writes to CSR/PROM stream len bytes. CSR reads add a
                    // trailing dummy byte. PROM reads and unknown targets
                    // are header only.
                    if (bus.req_we && !bus.req_target[1])
                        data_bytes = BC_W'(bus.req_len);
                    else if (!bus.req_we && bus.req_target == 2'b00)
                        data_bytes = BC_W'(bus.req_len) + BC_W'(1);
                    total_d = ((bus.req_target == 2'b01) ? BC_W'(3) : BC_W'(2))
                              + data_bytes;
                end
            end

            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // A pending unaccepted read byte blocks every load. This keeps
            // sck low until the host drains it, so rdata is never overwritten.
            LOAD: begin
                if (!(rvalid_q && !bus.rready)) begin
                    if (byte_cnt_q < hdr_len) begin
                        load_go   = 1'b1;
                        load_byte = hdr_byte;
                    end else if (we_q) begin
                        wready_c  = 1'b1;
                        load_go   = bus.wvalid;
                        load_byte = bus.wdata;
                    end else begin
                        load_go   = 1'b1;
                        load_byte = 8'h00;
                    end
                end
                if (load_go) begin
                    tx_d      = load_byte;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end

            // Each half period lasts CLK_DIV cycles and starts low, so bit 7
            // sits on mosi a full half period before the first rise.
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[5:0], miso};
                        if (bit_cnt_q == 3'd7 && rd_capture) begin
                            rdata_d  = {rx_q, miso};
                            rvalid_d = 1'b1;
                        end
                    end else begin
                        sck_d = 1'b0;
                        tx_d  = {tx_q[6:0], 1'b0};
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            state_d    = (byte_cnt_q + BC_W'(1) == total_q) ? HOLD : LOAD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    ss_d    = 1'b1;
                    done_d  = 1'b1;
                    tx_d    = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign sck           = sck_q;
    assign mosi          = tx_q[7];
    assign ss            = ss_q;
    assign bus.req_ready = (state_q == IDLE);
    assign bus.wready    = wready_c;
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_csr_spi_master.sv
// tb_csr_spi_master
//   Scoreboard bench for csr_spi_master. Tests push the expected mosi bytes
//   and read bytes into queues before they issue a request. An SPI slave
//   model and an rdata monitor pop and compare these entries as the DUT
//   produces them. Feeder processes drive the write stream and rready,
//   including deliberate stalls.
module tb_csr_spi_master;
    localparam int CLK_DIV = 4;
    localparam int LEN_W   = 12;
    localparam int SS_GAP  = 4;
    localparam int WPAUSE  = 50;
    localparam int RHOLD   = 60;

    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    logic rst;
    logic sck, mosi, miso, ss;

    csr_spi_master_if #(.LEN_W(LEN_W)) bus();

    csr_spi_master #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .SS_GAP(SS_GAP)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .sck  (sck),
        .mosi (mosi),
        .miso (miso),
        .ss   (ss)
    );

    always #5 clk = ~clk;

    byte_t exp_mosi[$];
    byte_t exp_rdata[$];
    byte_t miso_q[$];
    byte_t wq[$];

    int tests = 0;
    int fails = 0;
    int rise_cnt = 0;
    int done_cnt = 0;
    int wsent = 0;
    int wpause_at = -1;
    int wpause_len = 0;
    int pause_rise = 0;
    int rhold = 0;
    int rhold_rise = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // SPI slave model: it checks each completed mosi byte and shifts the
    // next miso byte out on sck falls.
    initial begin : spi_slave
        byte_t s_tx;
        byte_t s_rx;
        int    s_bits;
        logic  prev_sck;
        logic  prev_ss;
        s_tx = 8'h00; s_rx = 8'h00; s_bits = 0;
        prev_sck = 1'b0; prev_ss = 1'b1; miso = 1'b0;
        forever begin
            @(negedge clk);
            if (ss !== 1'b0) begin
                s_bits = 0;
            end else if (prev_ss === 1'b1) begin
                s_tx = 8'h00;
                if (miso_q.size() > 0) s_tx = miso_q.pop_front();
                miso = s_tx[7];
                s_bits = 0;
            end else if (sck === 1'b1 && prev_sck === 1'b0) begin
                s_rx = {s_rx[6:0], mosi};
                s_bits++;
                rise_cnt++;
                if (s_bits == 8) begin
                    if (exp_mosi.size() > 0) begin
                        checkOutput("mosi_byte", s_rx, exp_mosi.pop_front());
                    end else begin
                        tests++; fails++;
                        $display("[TB] FAIL mosi_unexpected: got 0x%0h, expected no byte", s_rx);
                    end
                end
            end else if (sck === 1'b0 && prev_sck === 1'b1) begin
                if (s_bits == 8) begin
                    s_bits = 0;
                    s_tx = 8'h00;
                    if (miso_q.size() > 0) s_tx = miso_q.pop_front();
                end else begin
                    s_tx = {s_tx[6:0], 1'b0};
                end
                miso = s_tx[7];
            end
            prev_sck = sck;
            prev_ss  = ss;
        end
    end

    // rdata monitor: pops and compares on every accepted read byte.
    initial begin : rd_monitor
        forever begin
            @(negedge clk);
            if (bus.rvalid === 1'b1 && bus.rready === 1'b1) begin
                if (exp_rdata.size() > 0) begin
                    checkOutput("rdata", bus.rdata, exp_rdata.pop_front());
                end else begin
                    tests++; fails++;
                    $display("[TB] FAIL rdata_unexpected: got 0x%0h, expected no byte", bus.rdata);
                end
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    // Write feeder: it can hold wvalid low for WPAUSE cycles of asserted
    // wready in front of data byte number wpause_at.
    initial begin : wfeed
        bit fire;
        bus.wvalid = 1'b0;
        bus.wdata  = 8'h00;
        forever begin
            @(negedge clk);
            fire = (bus.wvalid === 1'b1) && (bus.wready === 1'b1);
            @(posedge clk); #1;
            if (fire && wq.size() > 0) begin
                wq.delete(0);
                wsent++;
            end
            if (wsent == wpause_at && wpause_len > 0) begin
                bus.wvalid = 1'b0;
                if (bus.wready === 1'b1) begin
                    if (wpause_len == WPAUSE) pause_rise = rise_cnt;
                    if (wpause_len == WPAUSE / 2) begin
                        checkOutput("wstall_no_rises", rise_cnt, pause_rise);
                        checkOutput("wstall_sck_low", sck, 1'b0);
                        checkOutput("wstall_ss_low", ss, 1'b0);
                    end
                    wpause_len--;
                end
            end else begin
                bus.wvalid = (wq.size() > 0);
                bus.wdata  = (wq.size() > 0) ? wq[0] : 8'h00;
            end
        end
    end

    // rready feeder: it withholds rready for RHOLD cycles once rvalid rises.
    initial begin : rfeed
        bus.rready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rhold > 0 && bus.rvalid === 1'b1) begin
                bus.rready = 1'b0;
                if (rhold == RHOLD - 1) rhold_rise = rise_cnt;
                if (rhold == 10) begin
                    checkOutput("rstall_no_rises", rise_cnt, rhold_rise);
                    checkOutput("rstall_sck_low", sck, 1'b0);
                    checkOutput("rstall_ss_low", ss, 1'b0);
                end
                rhold--;
            end else begin
                bus.rready = 1'b1;
            end
        end
    end

    task automatic issueRequest(input logic [1:0] target, input logic we,
                                input logic [19:0] addr, input int len);
        bus.req_target = target;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_len    = LEN_W'(len);
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
    endtask

    task automatic applyStimulus(input string name, input logic [1:0] target, input logic we,
                                 input logic [19:0] addr, input int len, input int exp_rises);
        int rise0;
        int done0;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.req_ready === 1'b1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        checkOutput({name, "_req_ready"}, ok, 1'b1);
        rise0 = rise_cnt;
        done0 = done_cnt;
        issueRequest(target, we, addr, len);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (done_cnt != done0) begin ok = 1'b1; break; end
        end
        checkOutput({name, "_done_seen"}, ok, 1'b1);
        repeat (SS_GAP + 4) @(posedge clk);
        #1;
        checkOutput({name, "_sck_rises"}, rise_cnt - rise0, exp_rises);
        checkOutput({name, "_done_pulses"}, done_cnt - done0, 1);
        checkOutput({name, "_mosi_left"}, exp_mosi.size(), 0);
        checkOutput({name, "_rdata_left"}, exp_rdata.size(), 0);
        checkOutput({name, "_ss_high"}, ss, 1'b1);
        exp_mosi.delete();
        exp_rdata.delete();
        miso_q.delete();
        wq.delete();
    endtask

    initial begin : main
        bit ok;
        int rise0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_target = 2'b00;
        bus.req_addr   = '0;
        bus.req_len    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ss", ss, 1'b1);
        checkOutput("rst_sck", sck, 1'b0);
        checkOutput("rst_mosi", mosi, 1'b0);
        checkOutput("rst_rvalid", bus.rvalid, 1'b0);
        checkOutput("rst_wready", bus.wready, 1'b0);
        checkOutput("rst_done", bus.done, 1'b0);
        checkOutput("rst_req_ready", bus.req_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        // CSR write 0x01200, two data bytes
        wsent = 0;
        wq.push_back(8'h11); wq.push_back(8'h22);
        exp_mosi.push_back(8'h80); exp_mosi.push_back(8'h12);
        exp_mosi.push_back(8'h11); exp_mosi.push_back(8'h22);
        applyStimulus("csr_wr", 2'b00, 1'b1, 20'h01200, 2, 32);

        // CSR read 0x00300, two data bytes plus trailing dummy
        exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h03);
        exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h00);
        miso_q.push_back(8'h00); miso_q.push_back(8'hcc); miso_q.push_back(8'had);
        miso_q.push_back(8'h5a); miso_q.push_back(8'ha5);
        exp_rdata.push_back(8'h5a); exp_rdata.push_back(8'ha5);
        applyStimulus("csr_rd", 2'b00, 1'b0, 20'h00300, 2, 40);

        // PROM write 0x00104, eight bytes: 11 bytes with ss low
        wsent = 0;
        exp_mosi.push_back(8'h90); exp_mosi.push_back(8'h01); exp_mosi.push_back(8'h04);
        for (int i = 1; i <= 8; i++) begin
            wq.push_back(byte_t'(i));
            exp_mosi.push_back(byte_t'(i));
        end
        applyStimulus("prom_wr", 2'b01, 1'b1, 20'h00104, 8, 88);

        // CSR write with wvalid withheld before data byte 1
        wsent = 0;
        wpause_at = 1;
        wpause_len = WPAUSE;
        wq.push_back(8'h33); wq.push_back(8'h44);
        exp_mosi.push_back(8'h80); exp_mosi.push_back(8'hab);
        exp_mosi.push_back(8'h33); exp_mosi.push_back(8'h44);
        applyStimulus("csr_wr_wstall", 2'b00, 1'b1, 20'h0ab00, 2, 32);
        checkOutput("wstall_completed", wpause_len, 0);
        wpause_at = -1;

        // CSR read len 3 with rready withheld after the first read byte
        rhold = RHOLD;
        exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h05);
        for (int i = 0; i < 4; i++) exp_mosi.push_back(8'h00);
        miso_q.push_back(8'h00); miso_q.push_back(8'hcc); miso_q.push_back(8'had);
        miso_q.push_back(8'h11); miso_q.push_back(8'h22); miso_q.push_back(8'h33);
        exp_rdata.push_back(8'h11); exp_rdata.push_back(8'h22); exp_rdata.push_back(8'h33);
        applyStimulus("csr_rd_rstall", 2'b00, 1'b0, 20'h00500, 3, 48);
        checkOutput("rstall_completed", rhold, 0);

        // PROM read: header only, len ignored
        exp_mosi.push_back(8'h11); exp_mosi.push_back(8'h23); exp_mosi.push_back(8'h45);
        applyStimulus("prom_rd_hdr_only", 2'b01, 1'b0, 20'h12345, 4, 24);

        // CSR write with len 0: header only
        exp_mosi.push_back(8'h87); exp_mosi.push_back(8'hff);
        applyStimulus("csr_wr_len0", 2'b00, 1'b1, 20'h7ff00, 0, 16);

        // Unknown target: header only
        exp_mosi.push_back(8'hb0); exp_mosi.push_back(8'h0a);
        applyStimulus("tgt3_hdr_only", 2'b11, 1'b1, 20'h00a00, 3, 16);

        // Reset in the middle of PROM write byte 2 (after 20 sck rises)
        wsent = 0;
        exp_mosi.push_back(8'h90); exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h40);
        for (int i = 0; i < 4; i++) begin
            wq.push_back(byte_t'(8'ha1 + i));
            exp_mosi.push_back(byte_t'(8'ha1 + i));
        end
        rise0 = rise_cnt;
        issueRequest(2'b01, 1'b1, 20'h00040, 4);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (rise_cnt >= rise0 + 20) begin ok = 1'b1; break; end
        end
        checkOutput("midrst_reached", ok, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_ss", ss, 1'b1);
        checkOutput("midrst_sck", sck, 1'b0);
        checkOutput("midrst_req_ready", bus.req_ready, 1'b1);
        checkOutput("midrst_wready", bus.wready, 1'b0);
        checkOutput("midrst_mosi_left", exp_mosi.size(), 5);
        exp_mosi.delete();
        wq.delete();
        miso_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean request after the abort
        wsent = 0;
        wq.push_back(8'h11); wq.push_back(8'h22);
        exp_mosi.push_back(8'h80); exp_mosi.push_back(8'h12);
        exp_mosi.push_back(8'h11); exp_mosi.push_back(8'h22);
        applyStimulus("csr_wr_after_rst", 2'b00, 1'b1, 20'h01200, 2, 32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
